// File: rtl/bcd_pkg.sv
// Shared types for the digit-serial BCD add/subtract block.
package bcd_pkg;
  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_NEG,
    S_DONE
  } state_t;
endpackage

// File: rtl/bcd_digit_addsub.sv
// One packed-BCD digit add or subtract with carry/borrow in/out and decimal adjust.
module bcd_digit_addsub
  import bcd_pkg::*;
(
  input  bcd_digit_t x,
  input  bcd_digit_t z,
  input  logic       cin,
  input  logic       sub,
  output bcd_digit_t d,
  output logic       cout
);
  logic [BCD_W:0] s;

  always_comb begin
    s    = '0;
    d    = '0;
    cout = 1'b0;
    if (sub) begin
      // x - z - cin spans -10..9; bit 4 is the borrow of the 5-bit difference
      s = {1'b0, x} - {1'b0, z} - {{BCD_W{1'b0}}, cin};
      if (s[BCD_W]) begin
        d    = s[BCD_W-1:0] + 4'd10;
        cout = 1'b1;
      end else begin
        d = s[BCD_W-1:0];
      end
    end else begin
      s = {1'b0, x} + {1'b0, z} + {{BCD_W{1'b0}}, cin};
      if (s > 5'd9) begin
        d    = s[BCD_W-1:0] + 4'd6;
        cout = 1'b1;
      end else begin
        d = s[BCD_W-1:0];
      end
    end
  end
endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial NDIG-digit BCD adder/subtractor, LSD first, sign-magnitude result.
// Optional invalid-digit check enabled by defining BCD_CHECK_EN (adds the err port).
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter  int NDIG = 3,
  localparam int W    = BCD_W * NDIG
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] y,
  output logic         sign,
  output logic         ovf
`ifdef BCD_CHECK_EN
  ,output logic        err
`endif
);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t         state, state_nx;
  logic [W-1:0]   a_sr, b_sr, r_sr, r_nx;
  logic [IW-1:0]  idx;
  logic           carry, mode_r;
  logic           accept, last, fin;
  bcd_digit_t     ux, uz, ud;
  logic           usub, ucout;

  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign last   = (idx == IW'(NDIG - 1));

  // NEG reuses the digit unit as 0 - R to form the ten's complement magnitude
  always_comb begin
    ux   = (state == S_NEG) ? '0 : a_sr[BCD_W-1:0];
    uz   = (state == S_NEG) ? r_sr[BCD_W-1:0] : b_sr[BCD_W-1:0];
    usub = (state == S_NEG) || !mode_r;
    r_nx = r_sr >> BCD_W;
    r_nx[W-1 -: BCD_W] = ud;
  end

  bcd_digit_addsub u_digit (
    .x    (ux),
    .z    (uz),
    .cin  (carry),
    .sub  (usub),
    .d    (ud),
    .cout (ucout)
  );

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    fin      = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nx = S_CALC;
      S_CALC: begin
        busy = 1'b1;
        if (last) begin
          if (!mode_r && ucout) begin
            state_nx = S_NEG;
          end else begin
            state_nx = S_DONE;
            fin      = 1'b1;
          end
        end
      end
      S_NEG: begin
        busy = 1'b1;
        if (last) begin
          state_nx = S_DONE;
          fin      = 1'b1;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = accept ? S_CALC : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef BCD_CHECK_EN
  logic bad_in, bad_r;
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (a[i*BCD_W +: BCD_W] > 4'd9 || b[i*BCD_W +: BCD_W] > 4'd9) bad_in = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      mode_r <= 1'b0;
      y      <= '0;
      sign   <= 1'b0;
      ovf    <= 1'b0;
`ifdef BCD_CHECK_EN
      bad_r  <= 1'b0;
      err    <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sr   <= a;
        b_sr   <= b;
        r_sr   <= '0;
        mode_r <= mode;
        idx    <= '0;
        carry  <= 1'b0;
`ifdef BCD_CHECK_EN
        bad_r  <= bad_in;
        err    <= 1'b0;
`endif
      end else if (busy) begin
        a_sr  <= a_sr >> BCD_W;
        b_sr  <= b_sr >> BCD_W;
        r_sr  <= r_nx;
        idx   <= last ? '0 : idx + 1'b1;
        carry <= last ? 1'b0 : ucout;
      end
      if (fin) begin
        y    <= r_nx;
        sign <= (state == S_NEG);
        ovf  <= (state == S_CALC) && mode_r && ucout;
`ifdef BCD_CHECK_EN
        err  <= bad_r;
        if (bad_r) begin
          y    <= '0;
          sign <= 1'b0;
          ovf  <= 1'b0;
        end
`endif
      end
    end
  end
endmodule
